// File: rtl/per_clk_rst_sequencer.sv
// Per-channel peripheral reset/clock-enable sequencer: each channel runs its own
// RST -> DLY -> OFF/ON -> STOP FSM with registered Moore outputs.
module per_clk_rst_sequencer #(
  parameter int CH_NUM       = 4,
  parameter int RST_HOLD     = 4,
  parameter int CLK_DELAY    = 2,
  parameter int STOP_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] ch_en,
  input  logic [CH_NUM-1:0] sft_rst_req,
  input  logic [CH_NUM-1:0] per_idle,
  input  logic              arcg_on,
  input  logic              testmode,
  input  logic [CH_NUM-1:0] timeout_clr,
  output logic [CH_NUM-1:0] per_rst_n,
  output logic [CH_NUM-1:0] per_clk_en,
  output logic [CH_NUM-1:0] ch_busy,
  output logic [CH_NUM-1:0] stop_timeout
);

  localparam int MAX_AB = (RST_HOLD > CLK_DELAY) ? RST_HOLD : CLK_DELAY;
  localparam int MAX_P  = (MAX_AB > STOP_TIMEOUT) ? MAX_AB : STOP_TIMEOUT;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(CLK_DELAY - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RST,
    ST_DLY,
    ST_OFF,
    ST_ON,
    ST_STOP
  } state_e;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_set;
    logic          rstn_q, en_q, busy_q, to_q;

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      to_set  = 1'b0;
      unique case (state_q)
        ST_RST: begin
          if (sft_rst_req[g]) begin
            cnt_d = '0;
          end else if (cnt_q == RST_LAST) begin
            state_d = ST_DLY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DLY: begin
          if (sft_rst_req[g]) begin
            state_d = ST_RST;
            cnt_d   = '0;
          end else if (!arcg_on || cnt_q == DLY_LAST) begin
            state_d = ch_en[g] ? ST_ON : ST_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_OFF: begin
          if (sft_rst_req[g]) begin
            state_d = ST_RST;
            cnt_d   = '0;
          end else if (ch_en[g]) begin
            state_d = ST_ON;
          end
        end
        ST_ON: begin
          if (sft_rst_req[g]) begin
            state_d = ST_RST;
            cnt_d   = '0;
          end else if (!ch_en[g]) begin
            state_d = ST_STOP;
            cnt_d   = '0;
          end
        end
        ST_STOP: begin
          // Abort back to ON keeps the enable high throughout: no gate glitch.
          if (sft_rst_req[g]) begin
            state_d = ST_RST;
            cnt_d   = '0;
          end else if (ch_en[g]) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else if (per_idle[g]) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else if (cnt_q == STOP_LAST) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            to_set  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_RST;
          cnt_d   = '0;
        end
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_RST;
        cnt_q   <= '0;
        rstn_q  <= 1'b0;
        en_q    <= 1'b0;
        busy_q  <= 1'b1;
        to_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        // Outputs decoded from the next state so they change together with it.
        rstn_q  <= (state_d != ST_RST);
        en_q    <= (state_d == ST_ON) || (state_d == ST_STOP);
        busy_q  <= (state_d == ST_RST) || (state_d == ST_DLY) || (state_d == ST_STOP);
        to_q    <= to_set | (to_q & ~timeout_clr[g]);
      end
    end

    assign per_rst_n[g]    = rstn_q;
    assign per_clk_en[g]   = en_q | testmode;
    assign ch_busy[g]      = busy_q;
    assign stop_timeout[g] = to_q;
  end

endmodule

// File: tb/tb_per_clk_rst_sequencer.sv
// Scoreboard bench for per_clk_rst_sequencer: a countdown-based channel model
// predicts each cycle's outputs; a negedge monitor compares them.
module tb_per_clk_rst_sequencer;

  localparam int CH = 4;
  localparam int RH = 4;
  localparam int CD = 2;
  localparam int ST = 8;

  logic          i_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] ch_en = '0, sft_rst_req = '0, per_idle = '0, timeout_clr = '0;
  logic          arcg_on = 1'b1, testmode = 1'b0;
  logic [CH-1:0] per_rst_n, per_clk_en, ch_busy, stop_timeout;

  per_clk_rst_sequencer #(
    .CH_NUM(CH), .RST_HOLD(RH), .CLK_DELAY(CD), .STOP_TIMEOUT(ST)
  ) dut (
    .i_clk(i_clk), .rst_n(rst_n), .ch_en(ch_en), .sft_rst_req(sft_rst_req),
    .per_idle(per_idle), .arcg_on(arcg_on), .testmode(testmode),
    .timeout_clr(timeout_clr), .per_rst_n(per_rst_n), .per_clk_en(per_clk_en),
    .ch_busy(ch_busy), .stop_timeout(stop_timeout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [CH-1:0] rstn, clken, busy, to;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, failed = 0, cyc = 0;

  // Model: phase plus cycles remaining before the phase's timed exit.
  localparam int PH_RST = 0, PH_DLY = 1, PH_OFF = 2, PH_ON = 3, PH_STOP = 4;
  int phase[CH];
  int left[CH];
  bit to_flag[CH];

  task automatic check(input string name, input int c, input logic [CH-1:0] act,
                       input logic [CH-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      phase[c] = PH_RST; left[c] = RH; to_flag[c] = 1'b0;
    end
  endtask

  task automatic enter_reset(input int c);
    phase[c] = PH_RST; left[c] = RH;
  endtask

  task automatic model_step(input logic [CH-1:0] en, sft, idle, clr, input logic arcg);
    for (int c = 0; c < CH; c++) begin
      bit set = 1'b0;
      case (phase[c])
        PH_RST:
          if (sft[c]) left[c] = RH;
          else begin
            left[c]--;
            if (left[c] == 0) begin phase[c] = PH_DLY; left[c] = CD; end
          end
        PH_DLY:
          if (sft[c]) enter_reset(c);
          else begin
            left[c]--;
            if (left[c] == 0 || !arcg) phase[c] = en[c] ? PH_ON : PH_OFF;
          end
        PH_OFF:
          if (sft[c]) enter_reset(c);
          else if (en[c]) phase[c] = PH_ON;
        PH_ON:
          if (sft[c]) enter_reset(c);
          else if (!en[c]) begin phase[c] = PH_STOP; left[c] = ST; end
        default:
          if (sft[c]) enter_reset(c);
          else if (en[c]) phase[c] = PH_ON;
          else if (idle[c]) phase[c] = PH_OFF;
          else begin
            left[c]--;
            if (left[c] == 0) begin phase[c] = PH_OFF; set = 1'b1; end
          end
      endcase
      to_flag[c] = set | (to_flag[c] & ~clr[c]);
    end
  endtask

  function automatic exp_t model_out(input logic tm, input int c_no);
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      e.rstn[c]  = (phase[c] != PH_RST);
      e.clken[c] = (phase[c] == PH_ON) || (phase[c] == PH_STOP) || tm;
      e.busy[c]  = (phase[c] == PH_RST) || (phase[c] == PH_DLY) || (phase[c] == PH_STOP);
      e.to[c]    = to_flag[c];
    end
    e.cyc = c_no;
    return e;
  endfunction

  // One cycle of stimulus: applied just after negedge, outputs checked at the next negedge.
  task automatic drive(input logic rn, input logic [CH-1:0] en, sft, idle, clr,
                       input logic arcg, tm);
    @(negedge i_clk);
    #1;
    rst_n = rn; ch_en = en; sft_rst_req = sft; per_idle = idle; timeout_clr = clr;
    arcg_on = arcg; testmode = tm;
    cyc++;
    if (!rn) model_reset();
    else model_step(en, sft, idle, clr, arcg);
    sb.push_back(model_out(tm, cyc));
  endtask

  task automatic idle_cycles(input int n, input logic [CH-1:0] en, idle);
    for (int i = 0; i < n; i++) drive(1'b1, en, '0, idle, '0, 1'b1, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("per_rst_n", e.cyc, per_rst_n, e.rstn);
        check("per_clk_en", e.cyc, per_clk_en, e.clken);
        check("ch_busy", e.cyc, ch_busy, e.busy);
        check("stop_timeout", e.cyc, stop_timeout, e.to);
      end
    end
  end

  initial begin : stim
    logic [CH-1:0] en_r, sft_r, idle_r, clr_r;
    model_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b0001, '0, '0, '0, 1'b1, 1'b0);
    // Release with ch0 enabled: reset lifts after 4 edges, clock after 6.
    idle_cycles(10, 4'b0001, '0);
    idle_cycles(3, 4'b1111, '0);
    // ch0 stops on idle at its third STOP cycle; ch1 times out.
    drive(1'b1, 4'b1100, '0, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 4'b1100, '0, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 4'b1100, '0, 4'b0001, '0, 1'b1, 1'b0);
    idle_cycles(9, 4'b1100, '0);
    // ch2 soft-reset pulse, then a re-pulse during RST extends the hold.
    drive(1'b1, 4'b1100, 4'b0100, '0, '0, 1'b1, 1'b0);
    idle_cycles(2, 4'b1100, '0);
    drive(1'b1, 4'b1100, 4'b0100, '0, '0, 1'b1, 1'b0);
    idle_cycles(7, 4'b1100, '0);
    drive(1'b1, 4'b1100, '0, '0, 4'b0010, 1'b1, 1'b0);
    // ch3 enters STOP then is re-enabled before idle.
    drive(1'b1, 4'b0100, '0, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 4'b0100, '0, '0, '0, 1'b1, 1'b0);
    idle_cycles(3, 4'b1100, '0);
    // Mid-operation reset, release with arcg_on=0 and testmode pulsed in RST.
    drive(1'b0, 4'b1111, '0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 4'b1111, '0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 4'b1111, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 4'b1111, '0, '0, '0, 1'b0, 1'b0);
    // Randomized traffic.
    en_r = 4'b1010;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(7) == 0) en_r[c] = ~en_r[c];
        sft_r[c]  = ($urandom_range(39) == 0);
        idle_r[c] = ($urandom_range(5) == 0);
        clr_r[c]  = ($urandom_range(9) == 0);
      end
      drive(($urandom_range(299) != 0), en_r, sft_r, idle_r, clr_r,
            ($urandom_range(19) != 0), ($urandom_range(29) == 0));
    end
    @(negedge i_clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/per_clk_rst_sequencer.md
PER_CLK_RST_SEQUENCER -- requirements
Module: per_clk_rst_sequencer

Interface
REQ-001 SHALL have parameter CH_NUM, default 4: number of independent peripheral channels (range 1..32).
REQ-002 SHALL have parameter RST_HOLD, default 4: cycles per_rst_n is held low per reset entry (range 1..255).
REQ-003 SHALL have parameter CLK_DELAY, default 2: cycles between reset release and clock enable (range 1..255).
REQ-004 SHALL have parameter STOP_TIMEOUT, default 16: maximum cycles spent waiting for per_idle before forced clock stop (range 1..255).
REQ-005 SHALL have port i_clk, input, 1: the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port ch_en, input, CH_NUM: per-channel clock enable request (level).
REQ-008 SHALL have port sft_rst_req, input, CH_NUM: per-channel software reset request (level or pulse; sampled every cycle).
REQ-009 SHALL have port per_idle, input, CH_NUM: peripheral reports idle, safe to stop its clock.
REQ-010 SHALL have port arcg_on, input, 1: when 0, post-reset clock delay collapses to 1 cycle.
REQ-011 SHALL have port testmode, input, 1: forces all per_clk_en to 1.
REQ-012 SHALL have port timeout_clr, input, CH_NUM: clears the matching stop_timeout bit.
REQ-013 SHALL have port per_rst_n, output, CH_NUM: per-channel peripheral reset, active-low.
REQ-014 SHALL have port per_clk_en, output, CH_NUM: per-channel enable for the downstream clock gate.
REQ-015 SHALL have port ch_busy, output, CH_NUM: 1 while the channel is in RST, DLY or STOP.
REQ-016 SHALL have port stop_timeout, output, CH_NUM: sticky, set when a stop was forced by timeout.

Function
REQ-017 SHALL implement one independent FSM per channel with states RST, DLY, OFF, ON, STOP and one shared-width down/up counter per channel, width clog2(max(RST_HOLD,CLK_DELAY,STOP_TIMEOUT)+1).
REQ-018 RST: per_rst_n=0, per_clk_en=0; counter increments each cycle; at count RST_HOLD-1 -> DLY with counter cleared; sft_rst_req=1 while in RST clears the counter (hold extends).
REQ-019 DLY: per_rst_n=1, per_clk_en=0; after CLK_DELAY cycles (1 cycle if arcg_on=0 at any cycle in DLY) -> ON if ch_en=1 else OFF; sft_rst_req=1 -> RST.
REQ-020 OFF: per_rst_n=1, per_clk_en=0; sft_rst_req=1 -> RST (priority); else ch_en=1 -> ON.
REQ-021 ON: per_rst_n=1, per_clk_en=1; sft_rst_req=1 -> RST (priority, clock drops immediately); else ch_en=0 -> STOP with counter cleared.
REQ-022 STOP: per_clk_en stays 1; priority sft_rst_req -> RST, then ch_en=1 -> ON (abort), then per_idle=1 -> OFF, then counter reaching STOP_TIMEOUT-1 -> OFF and stop_timeout bit set.
REQ-023 per_rst_n, per_clk_en, ch_busy SHALL be driven from flops updated with the state (registered Moore outputs, no input-to-output combinational path) except the testmode override.
REQ-024 per_clk_en SHALL equal registered enable OR testmode; testmode SHALL NOT alter state, counters, per_rst_n.
REQ-025 stop_timeout set SHALL take priority over timeout_clr in the same cycle.
REQ-026 Each request input change SHALL be reflected in outputs exactly one cycle later (single-cycle transition latency); channels SHALL not interact.

Reset
REQ-027 While rst_n=0: all channels in RST with counter 0, per_rst_n=0, per_clk_en=0 (testmode=1 still forces per_clk_en=1), ch_busy=all 1, stop_timeout=0.
REQ-028 After rst_n rises, each channel SHALL run the full RST (RST_HOLD cycles) then DLY sequence before any clock enable.
REQ-029 rst_n asserted mid-operation in any state SHALL immediately return all outputs to REQ-027 values.

Verification (CH_NUM=4, RST_HOLD=4, CLK_DELAY=2, STOP_TIMEOUT=8)
REQ-030 Release rst_n with ch_en=4'b0001, arcg_on=1 -> per_rst_n=4'b1111 at cycle 4, per_clk_en[0]=1 at cycle 6, others 0, ch_busy=0 from cycle 6.
REQ-031 Ch0 in ON, drop ch_en[0], per_idle[0]=1 at cycle 3 -> per_clk_en[0] stays 1 for 3 cycles then 0; stop_timeout[0]=0.
REQ-032 Ch1 in ON, drop ch_en[1], per_idle[1]=0 -> per_clk_en[1] falls after 8 cycles, stop_timeout[1]=1 until timeout_clr[1].
REQ-033 Ch2 in ON, sft_rst_req[2] pulse 1 cycle -> per_clk_en[2]=0 and per_rst_n[2]=0 next cycle for 4 cycles, clock back 2 cycles after release; re-pulse during RST extends hold.
REQ-034 arcg_on=0 during release -> per_clk_en rises 1 cycle after per_rst_n; testmode=1 in RST -> per_clk_en=1111, per_rst_n unchanged.
REQ-035 Ch3 in STOP, ch_en[3] reasserted before idle -> returns to ON without per_clk_en glitch to 0.
